rsc2_dec_input_buffer: RTL and testbench

RSC2_DEC_INPUT_BUFFER -- requirements
Module: rsc2_dec_input_buffer

---
 rtl/rsc2_dec_input_buffer_pkg.sv | 25 ++
 rtl/rsc2_dec_tag_ram.sv | 35 +++
 rtl/rsc2_dec_input_buffer.sv | 152 +++++++++++++++
 tb/tb_rsc2_dec_input_buffer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rsc2_dec_input_buffer_pkg.sv
// Shared rsc2 decoder types for the input buffer.
//   bit_llr_t      : one soft bit at the default LLR width
//   cSEL_*         : iwsel target encodings (S, Y, W, discard)
//   cnt_next()     : used-bank counter update
package rsc2_dec_input_buffer_pkg;

  localparam int cLLR_W = 5;
  typedef logic signed [cLLR_W-1:0] bit_llr_t;

  localparam logic [1:0] cSEL_NONE = 2'b00;
  localparam logic [1:0] cSEL_Y    = 2'b01;
  localparam logic [1:0] cSEL_W    = 2'b10;
  localparam logic [1:0] cSEL_S    = 2'b11;

  // push and pop in the same cycle cancel out
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt,
                                          input logic inc, input logic dec);
    logic [1:0] r;
    r = cnt;
    if (inc && !dec) r = cnt + 2'd1;
    if (dec && !inc) r = cnt - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/rsc2_dec_tag_ram.sv
// Tagged dual-port word array: one write port, one registered read port.
// Each word carries a 1-bit epoch tag stored alongside the data; the reader
// decides validity. Contents are not reset.
//   iclk, iclkena         : clock / clock enable
//   iwe, iwaddr, iwdat    : write strobe, address, data
//   iwtag                 : epoch tag written with the data
//   iraddr                : read address (1-cycle latency)
//   ordat, ortag          : registered read data and tag
module rsc2_dec_tag_ram
  import rsc2_dec_input_buffer_pkg::*;
#(
  parameter int pDAT_W  = 10,
  parameter int pADDR_W = 8
) (
  input  logic               iclk,
  input  logic               iclkena,
  input  logic               iwe,
  input  logic [pADDR_W-1:0] iwaddr,
  input  logic [pDAT_W-1:0]  iwdat,
  input  logic               iwtag,
  input  logic [pADDR_W-1:0] iraddr,
  output logic [pDAT_W-1:0]  ordat,
  output logic               ortag
);

  logic [pDAT_W:0] r_mem [2**pADDR_W];

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (iwe) r_mem[iwaddr] <= {iwtag, iwdat};
      {ortag, ordat} <= r_mem[iraddr];
    end
  end

endmodule

// File: rtl/rsc2_dec_input_buffer.sv
// Ping-pong input buffer for the rsc2 decoder. Two banks, each with S, Y
// (and optionally W) tagged word arrays. A per-bank epoch bit replaces a
// bank clear: words written in an earlier epoch read back as 0.
// Optional feature macro: RSC2_DEC_INPUT_BUFFER_W_EN builds the W arrays;
// without it iwsel=10 writes are dropped and orwLLR is 0.
//   iclk/ireset/iclkena           : clock, async active-low reset, enable
//   iwrite/iwfull/iwsel/iwaddr    : write strobe, end-of-packet, target, addr
//   isLLR/iyLLR/iwLLR/iwtag       : write data pairs, packet tag
//   ofulla/oemptya/ordfull        : registered bank occupancy flags
//   irdone/iraddr                 : read bank release, read address
//   orsLLR/oryLLR/orwLLR/ortag    : read data (1-cycle) and read bank tag
//   oerr                          : sticky overflow
module rsc2_dec_input_buffer
  import rsc2_dec_input_buffer_pkg::*;
#(
  parameter int pLLR_W  = 5,
  parameter int pADDR_W = 8,
  parameter int pTAG_W  = 10
) (
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   iclkena,
  input  logic                   iwrite,
  input  logic                   iwfull,
  input  logic [1:0]             iwsel,
  input  logic [pADDR_W-1:0]     iwaddr,
  input  logic [1:0][pLLR_W-1:0] isLLR,
  input  logic [1:0][pLLR_W-1:0] iyLLR,
  input  logic [1:0][pLLR_W-1:0] iwLLR,
  input  logic [pTAG_W-1:0]      iwtag,
  output logic                   ofulla,
  output logic                   oemptya,
  output logic                   ordfull,
  input  logic                   irdone,
  input  logic [pADDR_W-1:0]     iraddr,
  output logic [1:0][pLLR_W-1:0] orsLLR,
  output logic [1:0][pLLR_W-1:0] oryLLR,
  output logic [1:0][pLLR_W-1:0] orwLLR,
  output logic [pTAG_W-1:0]      ortag,
  output logic                   oerr
);

  localparam int cDW = 2 * pLLR_W;

  logic                   r_wp, r_rp;
  logic [1:0]             r_cnt;
  logic [1:0]             r_ep;    // current write epoch per bank
  logic [1:0]             r_seen;  // bank has completed at least one packet
  logic [1:0][pTAG_W-1:0] r_tag;
  logic                   r_full, r_empty, r_rdfull, r_err;
  // read-side context captured with the address, aligned to RAM output
  logic                   r_rp_q, r_exp_q, r_ok_q;

  logic       w_room, w_wr, w_push, w_pop;
  logic [1:0] w_cnt_nxt;
  logic [1:0][cDW-1:0] w_s_dat, w_y_dat;
  logic [1:0]          w_s_tg, w_y_tg;

  assign w_room    = (r_cnt != 2'd2);
  assign w_wr      = iwrite && w_room && (iwsel != cSEL_NONE);
  assign w_push    = iwfull && w_room;
  assign w_pop     = irdone && (r_cnt != 2'd0);
  assign w_cnt_nxt = cnt_next(r_cnt, w_push, w_pop);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_ep     <= '0;
      r_seen   <= '0;
      r_tag    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rdfull <= 1'b0;
      r_err    <= 1'b0;
      r_rp_q   <= 1'b0;
      r_exp_q  <= 1'b0;
      r_ok_q   <= 1'b0;
    end else if (iclkena) begin
      // the same-cycle word write lands with the old epoch, before the toggle
      if (w_push) begin
        r_tag[r_wp]  <= iwtag;
        r_ep[r_wp]   <= ~r_ep[r_wp];
        r_seen[r_wp] <= 1'b1;
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == 2'd2);
      r_empty  <= (w_cnt_nxt == 2'd0);
      r_rdfull <= (w_cnt_nxt != 2'd0);
      if ((iwrite || iwfull) && !w_room) r_err <= 1'b1;
      // last completed epoch is the inverse of the one now being written
      r_rp_q  <= r_rp;
      r_exp_q <= ~r_ep[r_rp];
      r_ok_q  <= r_seen[r_rp];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rsc2_dec_tag_ram #(.pDAT_W(cDW), .pADDR_W(pADDR_W)) u_s (
      .iclk(iclk), .iclkena(iclkena),
      .iwe(w_wr && (iwsel == cSEL_S) && (r_wp == 1'(b))),
      .iwaddr(iwaddr), .iwdat(isLLR), .iwtag(r_ep[b]),
      .iraddr(iraddr), .ordat(w_s_dat[b]), .ortag(w_s_tg[b])
    );
    rsc2_dec_tag_ram #(.pDAT_W(cDW), .pADDR_W(pADDR_W)) u_y (
      .iclk(iclk), .iclkena(iclkena),
      .iwe(w_wr && (iwsel == cSEL_Y) && (r_wp == 1'(b))),
      .iwaddr(iwaddr), .iwdat(iyLLR), .iwtag(r_ep[b]),
      .iraddr(iraddr), .ordat(w_y_dat[b]), .ortag(w_y_tg[b])
    );
  end

  always_comb begin
    orsLLR = '0;
    oryLLR = '0;
    if (r_ok_q && (w_s_tg[r_rp_q] == r_exp_q)) orsLLR = w_s_dat[r_rp_q];
    if (r_ok_q && (w_y_tg[r_rp_q] == r_exp_q)) oryLLR = w_y_dat[r_rp_q];
  end

`ifdef RSC2_DEC_INPUT_BUFFER_W_EN
  logic [1:0][cDW-1:0] w_w_dat;
  logic [1:0]          w_w_tg;

  for (genvar b = 0; b < 2; b++) begin : g_wbank
    rsc2_dec_tag_ram #(.pDAT_W(cDW), .pADDR_W(pADDR_W)) u_w (
      .iclk(iclk), .iclkena(iclkena),
      .iwe(w_wr && (iwsel == cSEL_W) && (r_wp == 1'(b))),
      .iwaddr(iwaddr), .iwdat(iwLLR), .iwtag(r_ep[b]),
      .iraddr(iraddr), .ordat(w_w_dat[b]), .ortag(w_w_tg[b])
    );
  end

  always_comb begin
    orwLLR = '0;
    if (r_ok_q && (w_w_tg[r_rp_q] == r_exp_q)) orwLLR = w_w_dat[r_rp_q];
  end
`else
  logic w_unused_w;
  assign w_unused_w = ^iwLLR;
  assign orwLLR     = '0;
`endif

  assign ofulla  = r_full;
  assign oemptya = r_empty;
  assign ordfull = r_rdfull;
  assign oerr    = r_err;
  assign ortag   = r_tag[r_rp];

endmodule

// File: tb/tb_rsc2_dec_input_buffer.sv
module tb_rsc2_dec_input_buffer;
  import rsc2_dec_input_buffer_pkg::*;

  logic             iclk = 1'b0;
  logic             ireset = 1'b0;
  logic             iclkena = 1'b1;
  logic             iwrite = 1'b0, iwfull = 1'b0, irdone = 1'b0;
  logic [1:0]       iwsel = 2'b00;
  logic [7:0]       iwaddr = '0, iraddr = '0;
  logic [1:0][4:0]  isLLR = '0, iyLLR = '0, iwLLR = '0;
  logic [9:0]       iwtag = '0;
  logic             ofulla, oemptya, ordfull, oerr;
  logic [1:0][4:0]  orsLLR, oryLLR, orwLLR;
  logic [9:0]       ortag;

  int n_tests = 0;
  int n_fail  = 0;

  rsc2_dec_input_buffer #(.pLLR_W(5), .pADDR_W(8), .pTAG_W(10)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iwrite(iwrite), .iwfull(iwfull), .iwsel(iwsel), .iwaddr(iwaddr),
    .isLLR(isLLR), .iyLLR(iyLLR), .iwLLR(iwLLR), .iwtag(iwtag),
    .ofulla(ofulla), .oemptya(oemptya), .ordfull(ordfull),
    .irdone(irdone), .iraddr(iraddr),
    .orsLLR(orsLLR), .oryLLR(oryLLR), .orwLLR(orwLLR), .ortag(ortag),
    .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk); #1;
  endtask

  // one cycle of write-side/release stimulus; same data on all LLR inputs
  task automatic wr(input logic wen, input logic [1:0] sel, input logic [7:0] a,
                    input logic [9:0] dat, input logic full, input logic [9:0] tag,
                    input logic done);
    iwrite = wen; iwsel = sel; iwaddr = a;
    isLLR = dat; iyLLR = dat; iwLLR = dat;
    iwfull = full; iwtag = tag; irdone = done;
    step();
    iwrite = 1'b0; iwfull = 1'b0; irdone = 1'b0; iwsel = 2'b00;
  endtask

  task automatic rd(input logic [7:0] a);
    iraddr = a;
    step();
  endtask

  task automatic test_reset();
    ireset = 1'b0;
    step(); step();
    n_tests++; if (oemptya !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b want 1", oemptya); end
    n_tests++; if (ofulla !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b want 0", ofulla); end
    n_tests++; if (ordfull !== 1'b0) begin n_fail++; $display("FAIL rst_rdfull: got %0b want 0", ordfull); end
    n_tests++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", oerr); end
    n_tests++; if (ortag !== 10'h000) begin n_fail++; $display("FAIL rst_tag: got %h want 000", ortag); end
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL rst_sllr: got %h want 000", orsLLR); end
    ireset = 1'b1;
    step();
  endtask

  // S=3 at 0..3, Y=-2 at 0 and 2, W=7 at 0; last Y write shares the iwfull cycle
  task automatic test_basic();
    for (int i = 0; i < 4; i++) wr(1'b1, cSEL_S, 8'(i), 10'h063, 1'b0, 10'h000, 1'b0);
    wr(1'b1, cSEL_Y, 8'd0, 10'h3DE, 1'b0, 10'h000, 1'b0);
    wr(1'b1, cSEL_W, 8'd0, 10'h0E7, 1'b0, 10'h000, 1'b0);
    n_tests++; if (ordfull !== 1'b0) begin n_fail++; $display("FAIL basic_pre_rdfull: got %0b want 0", ordfull); end
    wr(1'b1, cSEL_Y, 8'd2, 10'h3DE, 1'b1, 10'h123, 1'b0);
    n_tests++; if (ordfull !== 1'b1) begin n_fail++; $display("FAIL basic_rdfull: got %0b want 1", ordfull); end
    n_tests++; if (oemptya !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %0b want 0", oemptya); end
    n_tests++; if (ofulla !== 1'b0) begin n_fail++; $display("FAIL basic_full: got %0b want 0", ofulla); end
    n_tests++; if (ortag !== 10'h123) begin n_fail++; $display("FAIL basic_tag: got %h want 123", ortag); end
    rd(8'd1);
    n_tests++; if (orsLLR !== 10'h063) begin n_fail++; $display("FAIL basic_s1: got %h want 063", orsLLR); end
    n_tests++; if (oryLLR !== 10'h000) begin n_fail++; $display("FAIL basic_y1: got %h want 000", oryLLR); end
    rd(8'd2);
    n_tests++; if (oryLLR !== 10'h3DE) begin n_fail++; $display("FAIL basic_y2: got %h want 3de", oryLLR); end
    rd(8'd0);
    n_tests++; if (oryLLR !== 10'h3DE) begin n_fail++; $display("FAIL basic_y0: got %h want 3de", oryLLR); end
    n_tests++; if (orwLLR !== 10'h000) begin n_fail++; $display("FAIL w_disabled: got %h want 000", orwLLR); end
  endtask

  task automatic test_clkena();
    iclkena = 1'b0;
    wr(1'b0, cSEL_NONE, 8'd0, 10'h000, 1'b0, 10'h000, 1'b1);
    iclkena = 1'b1;
    n_tests++; if (ordfull !== 1'b1) begin n_fail++; $display("FAIL clkena_hold: got %0b want 1", ordfull); end
    n_tests++; if (ortag !== 10'h123) begin n_fail++; $display("FAIL clkena_tag: got %h want 123", ortag); end
  endtask

  task automatic test_overflow();
    wr(1'b1, cSEL_S, 8'd0, 10'h0A5, 1'b1, 10'h2AA, 1'b0);
    n_tests++; if (ofulla !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %0b want 1", ofulla); end
    n_tests++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL ovf_err_pre: got %0b want 0", oerr); end
    wr(1'b1, cSEL_S, 8'd1, 10'h129, 1'b0, 10'h000, 1'b0);
    n_tests++; if (oerr !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %0b want 1", oerr); end
    wr(1'b0, cSEL_NONE, 8'd0, 10'h000, 1'b1, 10'h0F0, 1'b0);
    n_tests++; if (ofulla !== 1'b1) begin n_fail++; $display("FAIL ovf_full_hold: got %0b want 1", ofulla); end
    n_tests++; if (ortag !== 10'h123) begin n_fail++; $display("FAIL ovf_tag: got %h want 123", ortag); end
    rd(8'd1);
    n_tests++; if (orsLLR !== 10'h063) begin n_fail++; $display("FAIL ovf_keep: got %h want 063", orsLLR); end
  endtask

  task automatic test_back_to_back();
    wr(1'b0, cSEL_NONE, 8'd0, 10'h000, 1'b0, 10'h000, 1'b1);
    n_tests++; if (ofulla !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %0b want 0", ofulla); end
    n_tests++; if (ortag !== 10'h2AA) begin n_fail++; $display("FAIL b2b_tag1: got %h want 2aa", ortag); end
    rd(8'd0);
    n_tests++; if (orsLLR !== 10'h0A5) begin n_fail++; $display("FAIL b2b_s0: got %h want 0a5", orsLLR); end
    // refill bank 0 with only addr 5, completing and releasing in one cycle
    wr(1'b1, cSEL_S, 8'd5, 10'h084, 1'b1, 10'h155, 1'b1);
    n_tests++; if (ordfull !== 1'b1) begin n_fail++; $display("FAIL b2b_rdfull: got %0b want 1", ordfull); end
    n_tests++; if (ofulla !== 1'b0) begin n_fail++; $display("FAIL b2b_full2: got %0b want 0", ofulla); end
    n_tests++; if (oemptya !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b want 0", oemptya); end
    n_tests++; if (ortag !== 10'h155) begin n_fail++; $display("FAIL b2b_tag2: got %h want 155", ortag); end
  endtask

  task automatic test_refill();
    rd(8'd4);
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL refill_s4: got %h want 000", orsLLR); end
    rd(8'd2);
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL refill_s2: got %h want 000", orsLLR); end
    n_tests++; if (oryLLR !== 10'h000) begin n_fail++; $display("FAIL refill_y2: got %h want 000", oryLLR); end
    rd(8'd5);
    n_tests++; if (orsLLR !== 10'h084) begin n_fail++; $display("FAIL refill_s5: got %h want 084", orsLLR); end
    n_tests++; if (oerr !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b want 1", oerr); end
  endtask

  task automatic test_reset_mid();
    iwrite = 1'b1; iwsel = cSEL_S; iwaddr = 8'd0; isLLR = 10'h0C6;
    step();
    #2 ireset = 1'b0;
    #1;
    n_tests++; if (oemptya !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %0b want 1", oemptya); end
    n_tests++; if (ordfull !== 1'b0) begin n_fail++; $display("FAIL mid_rdfull: got %0b want 0", ordfull); end
    n_tests++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %0b want 0", oerr); end
    n_tests++; if (ortag !== 10'h000) begin n_fail++; $display("FAIL mid_tag: got %h want 000", ortag); end
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL mid_sllr: got %h want 000", orsLLR); end
    iwrite = 1'b0; iwsel = cSEL_NONE;
    step();
    ireset = 1'b1;
    rd(8'd0);
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL mid_s0: got %h want 000", orsLLR); end
    rd(8'd5);
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL mid_s5: got %h want 000", orsLLR); end
    n_tests++; if (oemptya !== 1'b1) begin n_fail++; $display("FAIL mid_empty2: got %0b want 1", oemptya); end
  endtask

  task automatic test_rdone_empty();
    wr(1'b0, cSEL_NONE, 8'd0, 10'h000, 1'b0, 10'h000, 1'b1);
    n_tests++; if (oemptya !== 1'b1) begin n_fail++; $display("FAIL rdone_empty: got %0b want 1", oemptya); end
    n_tests++; if (ordfull !== 1'b0) begin n_fail++; $display("FAIL rdone_rdfull: got %0b want 0", ordfull); end
    wr(1'b1, cSEL_S, 8'd7, 10'h3FF, 1'b1, 10'h3FF, 1'b0);
    n_tests++; if (ortag !== 10'h3FF) begin n_fail++; $display("FAIL post_tag: got %h want 3ff", ortag); end
    rd(8'd7);
    n_tests++; if (orsLLR !== 10'h3FF) begin n_fail++; $display("FAIL post_s7: got %h want 3ff", orsLLR); end
    rd(8'd5);
    n_tests++; if (orsLLR !== 10'h000) begin n_fail++; $display("FAIL post_s5: got %h want 000", orsLLR); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clkena();
    test_overflow();
    test_back_to_back();
    test_refill();
    test_reset_mid();
    test_rdone_empty();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
